// File: rtl/obi_bus_responder.sv
// Protocol-correct OBI memory responder driven by free solver bits for formal environments.
// Define OBI_RESP_FAIRNESS_EN to bound grant and response stalls by MAX_STALL cycles.
module obi_bus_responder #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned MAX_STALL       = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    input  logic        rand_gnt_i,
    input  logic        rand_rvalid_i,
    input  logic [31:0] rand_rdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [2:0]  outstanding_o,
    output logic        violation_o
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_fields_t;

    logic [2:0]  cnt_q;
    logic        room;
    logic        force_gnt;
    logic        force_rsp;
    logic        hold_valid_q;
    logic        violation_q;
    req_fields_t cur_req;
    req_fields_t held_q;

    assign cur_req = '{addr: addr_i, we: we_i, be: be_i, wdata: wdata_i};
    assign room    = (cnt_q < MAX_CNT);

    // Grant and response depend only on inputs and registered state, so no input-to-state loop.
    assign gnt_o    = !reset && req_i && room && (rand_gnt_i || force_gnt);
    assign rvalid_o = !reset && (cnt_q != 3'd0) && (rand_rvalid_i || force_rsp);
    assign rdata_o  = rvalid_o ? rand_rdata_i : 32'h0;

    // Registered status reads as zero while reset is held, even before the first clean edge.
    assign outstanding_o = reset ? 3'd0 : cnt_q;
    assign violation_o   = reset ? 1'b0 : violation_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_q + {2'b00, gnt_o} - {2'b00, rvalid_o};
        end
    end

    // A stalled request must stay asserted with identical fields until it is granted.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            violation_q  <= 1'b0;
        end else begin
            if (hold_valid_q && (!req_i || (cur_req != held_q))) begin
                violation_q <= 1'b1;
            end
            if (gnt_o) begin
                hold_valid_q <= 1'b0;
            end else if (req_i) begin
                hold_valid_q <= 1'b1;
            end
        end
    end

    // NOTE: the held copy is plain datapath with no reset; hold_valid_q alone qualifies it.
    always_ff @(posedge clock) begin
        if (req_i && !gnt_o) begin
            held_q <= cur_req;
        end
    end

`ifdef OBI_RESP_FAIRNESS_EN
    localparam logic [3:0] STALL_LIM = 4'(MAX_STALL);

    logic [3:0] gnt_wait_q;
    logic [3:0] rsp_wait_q;

    assign force_gnt = (gnt_wait_q == STALL_LIM);
    assign force_rsp = (rsp_wait_q == STALL_LIM);

    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_wait_q <= 4'd0;
            rsp_wait_q <= 4'd0;
        end else begin
            // A request blocked only by a full window keeps its accumulated wait.
            if (gnt_o || !req_i) begin
                gnt_wait_q <= 4'd0;
            end else if (room && (gnt_wait_q != STALL_LIM)) begin
                gnt_wait_q <= gnt_wait_q + 4'd1;
            end

            if (rvalid_o || (cnt_q == 3'd0)) begin
                rsp_wait_q <= 4'd0;
            end else if (rsp_wait_q != STALL_LIM) begin
                rsp_wait_q <= rsp_wait_q + 4'd1;
            end
        end
    end
`else
    assign force_gnt = 1'b0;
    assign force_rsp = 1'b0;
`endif

endmodule

// File: tb/tb_obi_bus_responder.sv
// Self-checking bench for obi_bus_responder: vector table, corner sequences, randomized model run.
module tb_obi_bus_responder;

    localparam int MAX_OUT   = 2;
    localparam int STALL_LIM = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rand_gnt_i;
    logic        rand_rvalid_i;
    logic [31:0] rand_rdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic [2:0]  outstanding_o;
    logic        violation_o;

    int total = 0;
    int bad   = 0;

    obi_bus_responder #(.MAX_OUTSTANDING(MAX_OUT), .MAX_STALL(STALL_LIM)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_i         (req_i),
        .addr_i        (addr_i),
        .we_i          (we_i),
        .be_i          (be_i),
        .wdata_i       (wdata_i),
        .rand_gnt_i    (rand_gnt_i),
        .rand_rvalid_i (rand_rvalid_i),
        .rand_rdata_i  (rand_rdata_i),
        .gnt_o         (gnt_o),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o),
        .outstanding_o (outstanding_o),
        .violation_o   (violation_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          rst;
        bit          req;
        bit          rg;
        bit          rr;
        logic [31:0] rd;
        bit          e_gnt;
        bit          e_rv;
        logic [31:0] e_rd;
        logic [2:0]  e_out;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit rst, input bit req, input bit rg, input bit rr, input logic [31:0] rd);
        reset         = rst;
        req_i         = req;
        rand_gnt_i    = rg;
        rand_rvalid_i = rr;
        rand_rdata_i  = rd;
    endtask

    // Reference model state: plain counts and a pending-request record.
    int          m_cnt;
    bit          m_pend;
    logic [68:0] m_held;
    bit          m_viol;
    int          m_gwait;
    int          m_rwait;
    bit          fair_en;

    initial begin
`ifdef OBI_RESP_FAIRNESS_EN
        fair_en = 1'b1;
`else
        fair_en = 1'b0;
`endif
        addr_i  = 32'h0000_0100;
        we_i    = 1'b0;
        be_i    = 4'hF;
        wdata_i = 32'h0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();

        // rst req rg rr rdata | gnt rvalid rdata outstanding
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        3'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        3'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF, 3'd1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hCAFE0001, 1'b1, 1'b1, 32'hCAFE0001, 3'd1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h11111111, 1'b1, 1'b0, 32'h0,        3'd1};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h22222222, 1'b0, 1'b0, 32'h0,        3'd2};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b1, 32'h12345678, 3'd2};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h33333333, 1'b1, 1'b0, 32'h0,        3'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h44444444, 1'b0, 1'b1, 32'h44444444, 3'd2};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h55555555, 1'b0, 1'b1, 32'h55555555, 3'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h66666666, 1'b0, 1'b0, 32'h0,        3'd0};

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].rg, vecs[i].rr, vecs[i].rd);
            #2;
            check($sformatf("vec%0d_gnt", i), gnt_o, vecs[i].e_gnt);
            check($sformatf("vec%0d_rvalid", i), rvalid_o, vecs[i].e_rv);
            check($sformatf("vec%0d_rdata", i), rdata_o, vecs[i].e_rd);
            check($sformatf("vec%0d_outstanding", i), outstanding_o, vecs[i].e_out);
            check($sformatf("vec%0d_violation", i), violation_o, 1'b0);
            tick();
        end

        // Reset with two transactions outstanding drops them.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5);
        #2;
        check("rst_mid_rvalid", rvalid_o, 1'b0);
        check("rst_mid_gnt", gnt_o, 1'b0);
        check("rst_mid_rdata", rdata_o, 32'h0);
        check("rst_mid_outstanding", outstanding_o, 3'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5);
        for (int i = 0; i < 3; i++) begin
            #2;
            check($sformatf("post_rst%0d_rvalid", i), rvalid_o, 1'b0);
            check($sformatf("post_rst%0d_outstanding", i), outstanding_o, 3'd0);
            tick();
        end

        // Address changes while the request is stalled.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        addr_i = 32'h1A00_0080;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        check("stab_gnt_stalled", gnt_o, 1'b0);
        check("stab_viol_clean", violation_o, 1'b0);
        tick();
        addr_i = 32'h1A00_0084;
        #2;
        check("stab_viol_not_yet", violation_o, 1'b0);
        tick();
        req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            check($sformatf("stab_viol_sticky%0d", i), violation_o, 1'b1);
            tick();
        end
        reset = 1'b1;
        #2;
        check("stab_viol_in_reset", violation_o, 1'b0);
        tick();
        reset = 1'b0;
        #2;
        check("stab_viol_after_reset", violation_o, 1'b0);
        tick();

`ifdef OBI_RESP_FAIRNESS_EN
        // Forced grant and forced response with the solver never volunteering.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            #2;
            check($sformatf("fair_gnt_c%0d", c), gnt_o, (c == STALL_LIM) ? 1'b1 : 1'b0);
            tick();
        end
        req_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #2;
            check($sformatf("fair_rvalid_c%0d", c), rvalid_o, (c == STALL_LIM) ? 1'b1 : 1'b0);
            tick();
        end
`endif

        // Randomized run against the reference model.
        m_cnt = 0; m_pend = 0; m_held = '0; m_viol = 0; m_gwait = 0; m_rwait = 0;
        for (int i = 0; i < 800; i++) begin
            bit          e_gnt;
            bit          e_rv;
            bit          room;
            int          old_cnt;
            logic [68:0] fields;

            reset = (i == 0) || ($urandom_range(0, 59) == 0);
            if (m_pend) begin
                req_i = ($urandom_range(0, 99) < 97);
                if ($urandom_range(0, 99) < 2) addr_i = $urandom;
            end else begin
                req_i   = $urandom_range(0, 1);
                addr_i  = $urandom;
                we_i    = $urandom_range(0, 1);
                be_i    = 4'($urandom);
                wdata_i = $urandom;
            end
            rand_gnt_i    = ($urandom_range(0, 3) == 0);
            rand_rvalid_i = ($urandom_range(0, 2) == 0);
            rand_rdata_i  = $urandom;
            fields        = {addr_i, we_i, be_i, wdata_i};
            #2;

            room  = (m_cnt < MAX_OUT);
            e_gnt = !reset && req_i && room && (rand_gnt_i || (fair_en && m_gwait == STALL_LIM));
            e_rv  = !reset && (m_cnt > 0) && (rand_rvalid_i || (fair_en && m_rwait == STALL_LIM));
            check("rnd_gnt", gnt_o, e_gnt);
            check("rnd_rvalid", rvalid_o, e_rv);
            check("rnd_rdata", rdata_o, e_rv ? rand_rdata_i : 32'h0);
            check("rnd_outstanding", outstanding_o, reset ? 32'd0 : 32'(m_cnt));
            check("rnd_violation", violation_o, reset ? 1'b0 : m_viol);
            tick();

            if (reset) begin
                m_cnt = 0; m_pend = 0; m_viol = 0; m_gwait = 0; m_rwait = 0;
            end else begin
                if (m_pend && (!req_i || fields != m_held)) m_viol = 1;
                if (e_gnt) m_pend = 0;
                else if (req_i) begin
                    m_pend = 1;
                    m_held = fields;
                end
                old_cnt = m_cnt;
                m_cnt   = m_cnt + int'(e_gnt) - int'(e_rv);
                if (e_gnt || !req_i) m_gwait = 0;
                else if (room && m_gwait < STALL_LIM) m_gwait++;
                if (e_rv || old_cnt == 0) m_rwait = 0;
                else if (m_rwait < STALL_LIM) m_rwait++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
